muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide unit for MULT/MULTU/DIV/DIVU.
// Owns HI/LO, stalls the front of the pipeline while busy, and aborts on a MEM branch flush.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            n_rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            div_by_zero_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIXUP,
        S_DONE
    } state_t;

    // op[1] selects divide, op[0] selects the unsigned variant
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [XLEN-1:0]     opa_q, opa_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                dz_q, dz_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;

    logic                accept;
    logic                in_neg_a, in_neg_b;
    logic [XLEN-1:0]     in_mag_a, in_mag_b;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_rem_sh;
    logic                div_ge;
    logic [XLEN-1:0]     div_diff;
    logic [2*XLEN-1:0]   div_next;
    logic [XLEN-1:0]     quot, rem, orig_a;

    // Datapath terms shared by the FSM below.
    always_comb begin
        accept   = (state_q == S_IDLE) && start_i && !flush_i;
        in_neg_a = !op_i[0] && a_i[XLEN-1];
        in_neg_b = !op_i[0] && b_i[XLEN-1];
        in_mag_a = in_neg_a ? -a_i : a_i;
        in_mag_b = in_neg_b ? -b_i : b_i;

        // Multiply: {upper product, remaining multiplier bits} shifts right each step.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Divide: the partial remainder is always below the divisor, so the shifted
        // value needs one extra bit and the difference fits back into XLEN bits.
        div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
        div_ge     = div_rem_sh >= {1'b0, opb_q};
        div_diff   = div_rem_sh[XLEN-1:0] - opb_q;
        div_next   = {(div_ge ? div_diff : div_rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

        quot   = acc_q[XLEN-1:0];
        rem    = acc_q[2*XLEN-1:XLEN];
        orig_a = sign_a_q ? -opa_q : opa_q;
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d     = op_i;
                    opa_d    = in_mag_a;
                    opb_d    = in_mag_b;
                    sign_a_d = in_neg_a;
                    sign_b_d = in_neg_b;
                    dz_d     = 1'b0;
                    cnt_d    = '0;
                    // Multiplier rides in the low half; dividend becomes the quotient seed.
                    acc_d    = {{XLEN{1'b0}}, (op_i[1] ? in_mag_a : in_mag_b)};
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                if (flush_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = op_q[1] ? div_next : mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) begin
                        cnt_d   = '0;
                        state_d = S_FIXUP;
                    end
                end
            end

            S_FIXUP: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (!op_q[1]) begin
                        if (sign_a_q ^ sign_b_q) acc_d = -acc_q;
                    end else if (opb_q == '0) begin
                        acc_d = {orig_a, {XLEN{1'b1}}};
                        dz_d  = 1'b1;
                    end else begin
                        acc_d = {(sign_a_q ? -rem : rem),
                                 ((sign_a_q ^ sign_b_q) ? -quot : quot)};
                    end
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (!flush_i) begin
                    hi_d = acc_q[2*XLEN-1:XLEN];
                    lo_d = acc_q[XLEN-1:0];
                end
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Stall drops in DONE so the instruction leaves EX on that edge and is not re-issued.
    assign stall_o       = accept || (state_q == S_RUN) || (state_q == S_FIXUP);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign div_by_zero_o = (state_q == S_DONE) && dz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a scoreboard queue of expected HI/LO/dz
// results is drained by a monitor that fires on every done_o pulse.
module tb_muldiv_sequencer;

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic        div_by_zero_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    logic pend = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   stall_cnt = 0;
    int   cyc = 0;
    int   done_cyc[$];

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk_i         (clk_i),
        .n_rst_i       (n_rst_i),
        .start_i       (start_i),
        .op_i          (op_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .div_by_zero_o (div_by_zero_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc = cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: dz is checked with done_o, HI/LO one cycle later once written.
    always @(negedge clk_i) begin
        if (stall_o) stall_cnt++;
        if (pend) begin
            check("hi", hi_o, cur.hi);
            check("lo", lo_o, cur.lo);
            pend = 1'b0;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done_o required=no_done");
            end else begin
                cur = sb_q.pop_front();
                check("div_by_zero", 32'(div_by_zero_o), 32'(cur.dz));
                pend = 1'b1;
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.dz = dz;
        return e;
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 100) begin
            @(negedge clk_i); #1;
            n++;
        end
        check("done_within_budget", 32'(done_cnt >= target), 32'd1);
        @(negedge clk_i); #1;
        @(negedge clk_i); #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        int target;
        target = done_cnt + 1;
        sb_q.push_back(mk(hi, lo, dz));
        start_op(op, a, b);
        wait_done(target);
    endtask

    initial begin
        int d0;
        int n;
        n_rst_i = 1'b0;
        start_i = 1'b0;
        op_i    = '0;
        a_i     = '0;
        b_i     = '0;
        flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        n_rst_i = 1'b1;

        // MULTU with stall-length measurement
        stall_cnt = 0;
        d0 = done_cnt;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        check("multu_stall_cycles", 32'(stall_cnt), 32'd34);
        check("multu_done_pulses", 32'(done_cnt - d0), 32'd1);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'd30, 1'b0);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op(OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

        // Asynchronous reset mid-RUN discards everything
        run_op(OP_MULTU, 32'd9, 32'd9, 32'h0, 32'd81, 1'b0);
        start_op(OP_MULTU, 32'd5, 32'd6);
        repeat (5) @(posedge clk_i);
        #1 n_rst_i = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(busy_o), 32'd0);
        check("midrun_rst_stall", 32'(stall_o), 32'd0);
        check("midrun_rst_hi", hi_o, 32'd0);
        check("midrun_rst_lo", lo_o, 32'd0);
        @(posedge clk_i); #1;
        n_rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("post_rst_stall", 32'(stall_o), 32'd0);
        check("post_rst_busy", 32'(busy_o), 32'd0);

        // Flush at RUN cycle 10
        run_op(OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        d0 = done_cnt;
        start_op(OP_DIVU, 32'd50, 32'd3);
        repeat (9) @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush_run_busy", 32'(busy_o), 32'd0);
        check("flush_run_stall", 32'(stall_o), 32'd0);
        repeat (40) @(posedge clk_i);
        #1;
        check("flush_run_no_done", 32'(done_cnt - d0), 32'd0);
        check("flush_run_hi", hi_o, 32'h1234_5678);
        check("flush_run_lo", lo_o, 32'hFFFF_FFFF);

        // Flush during DONE: done_o still pulses, HI/LO keep their values
        d0 = done_cnt;
        sb_q.push_back(mk(32'h1234_5678, 32'hFFFF_FFFF, 1'b0));
        start_op(OP_DIVU, 32'd50, 32'd3);
        repeat (33) @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        wait_done(d0 + 1);

        // Back-to-back with start_i held high throughout
        d0 = done_cnt;
        sb_q.push_back(mk(32'h0, 32'd30, 1'b0));
        sb_q.push_back(mk(32'd2, 32'd14, 1'b0));
        @(posedge clk_i); #1;
        start_i = 1'b1;
        op_i    = OP_MULTU;
        a_i     = 32'd5;
        b_i     = 32'd6;
        n = 0;
        do begin
            @(negedge clk_i); #1;
            n++;
        end while (!done_o && n < 100);
        op_i = OP_DIVU;
        a_i  = 32'd100;
        b_i  = 32'd7;
        n = 0;
        do begin
            @(negedge clk_i); #1;
            n++;
        end while (!done_o && n < 100);
        start_i = 1'b0;
        repeat (40) @(posedge clk_i);
        #1;
        check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);
        if (done_cyc.size() >= 2)
            check("b2b_spacing", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'd35);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
